regfile_2r1w_sweep: RTL and testbench
=====================================

Name: regfile_2r1w_sweep

Overview:
- Parametrised successor to the single-port register file.
- 2^W1 registers of W2 bits, one write port and two independent read ports with registered (1-cycle) read data.
- Per-register synchronous clear, plus a hardware init sweep that reloads every register with IV, one register per cycle, under a small FSM.
- Sits in the datapath as the general-purpose register bank behind the control unit.

Parameters:
W1, 2, address width; depth = 2^W1 registers
W2, 8, data width
IV, {W2{1'b0}}, reset/clear/sweep load value

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset
we  input  1  write enable
wa  input  W1  write address
wd  input  W2  write data
ra0  input  W1  read address, port 0
ra1  input  W1  read address, port 1
rd0  output  W2  registered read data, port 0
rd1  output  W2  registered read data, port 1
clr  input  2^W1  per-register synchronous clear mask, bit i clears register i
init  input  1  start init sweep, sampled as a level
busy  output  1  sweep in progress
done  output  1  one-cycle pulse when sweep completes
wdrop  output  1  one-cycle pulse, write request rejected

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers = IV; rd0 = rd1 = IV.
  - busy = 0, done = 0, wdrop = 0.
  - FSM goes to IDLE and the sweep index is 0.
  - Reset in mid-sweep aborts the sweep immediately. done is not pulsed.
- Read:
  - rd0 <= mem[ra0] and rd1 <= mem[ra1] on every edge, giving 1-cycle latency.
  - Both ports may address the same register.
  - Reads continue during a sweep and return the current contents.
- Write:
  - In IDLE, we=1 loads mem[wa] <= wd on the edge.
- Register update priority, per register, same edge: sweep load > clr > write.
  - clr[i]=1 together with we=1 and wa=i: register i = IV, and wdrop is not raised.
  - A write to register j while clr targets only register i≠j: both take effect.
- FSM states:
  - IDLE: busy=0. init=1 -> SWEEP, with idx=0.
  - SWEEP: busy=1. Each cycle mem[idx] <= IV and idx <= idx+1. When idx = 2^W1-1 is loaded -> DONE. Sweep length is exactly 2^W1 cycles.
  - DONE: busy=0, done=1 for one cycle -> IDLE. init is ignored in DONE.
- init while in SWEEP or DONE: ignored; the sweep is not restarted.
- we=1 while busy=1: the write is discarded and wdrop=1 on the following cycle, for one cycle.
- Read-during-write, same address and same edge: behaviour is set by the optional feature.
- Index wrap: idx is W1 bits wide and returns to 0 after the last register. There is no overflow state.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: if we=1 is accepted (IDLE, not overridden by clr) and wa==ra0, then rd0 <= wd. rd1 behaves the same way with ra1. This forwards the new value with 1-cycle latency.
- If clr overrides the write on that register, rd gets IV.
- Not defined: rd gets the pre-write contents of the register. The new value is visible from the next read onward.

Test Plan:
1. Reset, then release rst -> rd0 = rd1 = 0x00 and busy = 0. Read all 4 addresses -> 0x00 each.
2. Write 0x01, 0x02, 0x04, 0x08 to regs 0..3. Then set ra0 = 0..3 and ra1 = 3..0 -> one cycle later rd0 = 0x01, 0x02, 0x04, 0x08 and rd1 = 0x08, 0x04, 0x02, 0x01.
3. Regs hold 0x01..0x08. Pulse clr = 4'b0100 while writing wa=1, wd=0xAA -> reg2 = 0x00, reg1 = 0xAA, regs 0 and 3 unchanged. Repeat with clr = 4'b0010, wa=1, wd=0x55 -> reg1 = 0x00 and wdrop stays 0.
4. Assert init for 1 cycle -> busy = 1 for exactly 4 cycles, then done = 1 for 1 cycle. All regs read 0x00. A write of 0x77 issued during busy -> wdrop pulses once and the target register stays 0x00.
5. Start a sweep, then drive rst=0 at sweep cycle 2 -> outputs reset immediately, done is never pulsed, and the FSM is in IDLE after release.
6. Reg1 = 0x10. In the same cycle write wa=1, wd=0x99 and set ra0=1 -> with REGFILE_BYPASS_EN, rd0 = 0x99 on the next cycle; without it, rd0 = 0x10, then 0x99 one cycle later.

Source files
------------

// File: rtl/regfile_2r1w_sweep_if.sv
// Bus bundle for regfile_2r1w_sweep: write port, two read ports, clear mask and sweep control.
// master drives requests, slave (the register file) returns read data and status.
interface regfile_2r1w_sweep_if #(
  parameter int unsigned W1 = 2,
  parameter int unsigned W2 = 8
);
  logic                  we;
  logic [W1-1:0]         wa;
  logic [W2-1:0]         wd;
  logic [W1-1:0]         ra0;
  logic [W1-1:0]         ra1;
  logic [W2-1:0]         rd0;
  logic [W2-1:0]         rd1;
  logic [(1 << W1)-1:0]  clr;
  logic                  init;
  logic                  busy;
  logic                  done;
  logic                  wdrop;

  modport master (
    output we, wa, wd, ra0, ra1, clr, init,
    input  rd0, rd1, busy, done, wdrop
  );

  modport slave (
    input  we, wa, wd, ra0, ra1, clr, init,
    output rd0, rd1, busy, done, wdrop
  );
endinterface

// File: rtl/regfile_2r1w_sweep.sv
// 2^W1 x W2 register file, one write / two registered read ports, per-register clear and an
// init sweep FSM. Optional macro REGFILE_BYPASS_EN forwards same-edge write data to the read ports.
module regfile_2r1w_sweep #(
  parameter int unsigned   W1 = 2,
  parameter int unsigned   W2 = 8,
  parameter logic [W2-1:0] IV = '0
) (
  input logic                  clk,
  input logic                  rst,
  regfile_2r1w_sweep_if.slave  bus
);
  localparam int unsigned Depth = 1 << W1;

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  state_e        state_q, state_d;
  logic [W1-1:0] idx_q, idx_d;
  logic [W2-1:0] mem_q [Depth];
  logic [W2-1:0] mem_d [Depth];
  logic [W2-1:0] rd0_q, rd0_d;
  logic [W2-1:0] rd1_q, rd1_d;
  logic          wdrop_q, wdrop_d;
  logic          wr_acc;

  assign wr_acc = bus.we && (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      StIdle: begin
        if (bus.init) begin
          state_d = StSweep;
          idx_d   = '0;
        end
      end
      StSweep: begin
        idx_d = idx_q + W1'(1);
        if (&idx_q) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Per-register priority: sweep load, then clear, then write.
  always_comb begin
    for (int unsigned i = 0; i < Depth; i++) begin
      mem_d[i] = mem_q[i];
      if ((state_q == StSweep) && (idx_q == W1'(i))) begin
        mem_d[i] = IV;
      end else if (bus.clr[i]) begin
        mem_d[i] = IV;
      end else if (wr_acc && (bus.wa == W1'(i))) begin
        mem_d[i] = bus.wd;
      end
    end
  end

  always_comb begin
    rd0_d = mem_q[bus.ra0];
    rd1_d = mem_q[bus.ra1];
`ifdef REGFILE_BYPASS_EN
    if (wr_acc && (bus.wa == bus.ra0)) rd0_d = bus.clr[bus.wa] ? IV : bus.wd;
    if (wr_acc && (bus.wa == bus.ra1)) rd1_d = bus.clr[bus.wa] ? IV : bus.wd;
`endif
    // Any write outside IDLE is rejected and flagged.
    wdrop_d = bus.we && (state_q != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      rd0_q   <= IV;
      rd1_q   <= IV;
      wdrop_q <= 1'b0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= IV;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      wdrop_q <= wdrop_d;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign bus.rd0   = rd0_q;
  assign bus.rd1   = rd1_q;
  assign bus.busy  = (state_q == StSweep);
  assign bus.done  = (state_q == StDone);
  assign bus.wdrop = wdrop_q;
endmodule

// File: tb/tb_regfile_2r1w_sweep.sv
// Scoreboard bench for regfile_2r1w_sweep: driver updates an array model and queues the
// expected post-edge outputs; a monitor pops and compares after every rising edge.
module tb_regfile_2r1w_sweep;
  logic clk;
  logic rst;

  regfile_2r1w_sweep_if #(.W1(2), .W2(8)) bus_if ();

  regfile_2r1w_sweep #(.W1(2), .W2(8), .IV(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct packed {
    logic [7:0] rd0;
    logic [7:0] rd1;
    logic       busy;
    logic       done;
    logic       wdrop;
  } obs_t;

  obs_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Model: register contents, sweep position (-1 when not sweeping), done-cycle flag.
  logic [7:0] m_mem [4];
  int         m_pos;
  bit         m_done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic obs_t sample();
    obs_t o;
    o.rd0   = bus_if.rd0;
    o.rd1   = bus_if.rd1;
    o.busy  = bus_if.busy;
    o.done  = bus_if.done;
    o.wdrop = bus_if.wdrop;
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got rd0=%h rd1=%h busy=%b done=%b wdrop=%b, want rd0=%h rd1=%h busy=%b done=%b wdrop=%b",
               name, $time, act.rd0, act.rd1, act.busy, act.done, act.wdrop,
               req.rd0, req.rd1, req.busy, req.done, req.wdrop);
    end
  endtask

  // Drive one cycle of inputs now and queue what the next rising edge must produce.
  task automatic apply(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                       input logic [1:0] ra0, input logic [1:0] ra1,
                       input logic [3:0] clr, input logic init);
    obs_t       e;
    bit         sweeping;
    bit         idle;
    bit         wr_ok;
    logic [7:0] nm [4];
    bus_if.we   = we;
    bus_if.wa   = wa;
    bus_if.wd   = wd;
    bus_if.ra0  = ra0;
    bus_if.ra1  = ra1;
    bus_if.clr  = clr;
    bus_if.init = init;
    sweeping = (m_pos >= 0);
    idle     = !sweeping && !m_done;
    wr_ok    = idle && we;
    e.rd0    = m_mem[ra0];
    e.rd1    = m_mem[ra1];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && wa == ra0) e.rd0 = clr[wa] ? 8'h00 : wd;
    if (wr_ok && wa == ra1) e.rd1 = clr[wa] ? 8'h00 : wd;
`endif
    e.wdrop = we && !idle;
    for (int i = 0; i < 4; i++) begin
      nm[i] = m_mem[i];
      if (sweeping && m_pos == i)      nm[i] = 8'h00;
      else if (clr[i])                 nm[i] = 8'h00;
      else if (wr_ok && int'(wa) == i) nm[i] = wd;
    end
    for (int i = 0; i < 4; i++) m_mem[i] = nm[i];
    if (sweeping) begin
      if (m_pos == 3) begin
        m_pos  = -1;
        m_done = 1'b1;
      end else begin
        m_pos++;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (init) begin
      m_pos = 0;
    end
    e.busy = (m_pos >= 0);
    e.done = m_done;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                      input logic [1:0] ra0, input logic [1:0] ra1,
                      input logic [3:0] clr, input logic init);
    @(negedge clk);
    apply(we, wa, wd, ra0, ra1, clr, init);
  endtask

  task automatic rd(input logic [1:0] a0, input logic [1:0] a1);
    step(1'b0, 2'd0, 8'h00, a0, a1, 4'b0000, 1'b0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    step(1'b1, a, d, 2'd0, 2'd0, 4'b0000, 1'b0);
  endtask

  // Assert reset now, check the asynchronous response, then release on a falling edge.
  task automatic hold_reset();
    obs_t z;
    z = '0;
    rst = 1'b0;
    #1;
    check("async_reset", sample(), z);
    exp_q.delete();
    for (int i = 0; i < 4; i++) m_mem[i] = 8'h00;
    m_pos  = -1;
    m_done = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_hold", sample(), z);
    rst = 1'b1;
    apply(1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 4'b0000, 1'b0);
  endtask

  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL scoreboard_underflow at %0t: got empty queue, want an entry", $time);
        end else begin
          e = exp_q.pop_front();
          check("scoreboard", sample(), e);
        end
      end
    end
  end

  initial begin
    logic [3:0] rclr;
    rst         = 1'b1;
    bus_if.we   = 1'b0;
    bus_if.wa   = '0;
    bus_if.wd   = '0;
    bus_if.ra0  = '0;
    bus_if.ra1  = '0;
    bus_if.clr  = '0;
    bus_if.init = 1'b0;
    #1;
    hold_reset();

    // Reset contents on every address.
    for (int i = 0; i < 4; i++) rd(2'(i), 2'(3 - i));

    // Walking-one writes, crossed reads.
    for (int i = 0; i < 4; i++) wr(2'(i), 8'h01 << i);
    for (int i = 0; i < 4; i++) rd(2'(i), 2'(3 - i));
    rd(2'd0, 2'd0);

    // Clear vs write on different and on the same register.
    step(1'b1, 2'd1, 8'hAA, 2'd0, 2'd0, 4'b0100, 1'b0);
    for (int i = 0; i < 4; i++) rd(2'(i), 2'(i));
    step(1'b1, 2'd1, 8'h55, 2'd1, 2'd1, 4'b0010, 1'b0);
    for (int i = 0; i < 4; i++) rd(2'(i), 2'(3 - i));

    // Full sweep with a dropped write during busy.
    for (int i = 0; i < 4; i++) wr(2'(i), 8'h30 + 8'(i));
    step(1'b0, 2'd0, 8'h00, 2'd0, 2'd3, 4'b0000, 1'b1);
    step(1'b1, 2'd2, 8'h77, 2'd2, 2'd1, 4'b0000, 1'b0);
    for (int i = 0; i < 6; i++) rd(2'(i), 2'(3 - i));

    // Reset two cycles into a sweep.
    for (int i = 0; i < 4; i++) wr(2'(i), 8'hC0 + 8'(i));
    step(1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 4'b0000, 1'b1);
    rd(2'd1, 2'd2);
    rd(2'd2, 2'd3);
    @(negedge clk);
    #2;
    hold_reset();
    for (int i = 0; i < 4; i++) wr(2'(i), 8'hE0 + 8'(i));
    step(1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 4'b0000, 1'b1);
    for (int i = 0; i < 7; i++) rd(2'(i), 2'(i + 1));

    // Read-during-write on the same address.
    wr(2'd1, 8'h10);
    step(1'b1, 2'd1, 8'h99, 2'd1, 2'd1, 4'b0000, 1'b0);
    rd(2'd1, 2'd1);
    step(1'b1, 2'd3, 8'h5A, 2'd3, 2'd3, 4'b1000, 1'b0);
    rd(2'd3, 2'd3);

    // Random traffic with one reset in the middle.
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        @(negedge clk);
        #2;
        hold_reset();
      end
      rclr = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      step(1'($urandom), 2'($urandom), 8'($urandom), 2'($urandom), 2'($urandom), rclr,
           ($urandom_range(0, 19) == 0));
    end

    @(posedge clk);
    #2;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
